oc8051_intc: RTL and testbench



---
 rtl/oc8051_intc_pkg.sv | 27 ++
 rtl/oc8051_intc_arb.sv | 27 ++
 rtl/oc8051_intc.sv | 188 ++++++++++++++++++
 tb/tb_oc8051_intc.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/oc8051_intc_pkg.sv
// Shared constants and helpers for the oc8051 nesting interrupt controller.
package oc8051_intc_pkg;

    // SFR offsets relative to the controller base address
    localparam logic [7:0] OFS_GCTL = 8'd0;
    localparam logic [7:0] OFS_IEN  = 8'd1;
    localparam logic [7:0] OFS_ITYP = 8'd2;
    localparam logic [7:0] OFS_IFLG = 8'd3;
    localparam logic [7:0] OFS_IPL0 = 8'd4;
    localparam logic [7:0] OFS_IPL1 = 8'd5;
    localparam logic [7:0] NUM_REGS = 8'd6;

    // Default vector layout: classic 8051 spacing starting at 0x03
    localparam logic [7:0] DEF_VEC_BASE = 8'h03;
    localparam logic [7:0] DEF_VEC_STEP = 8'h08;

    // Index of the highest set bit of an active-level mask; 0 when empty
    function automatic logic [1:0] hi_bit(input logic [3:0] mask);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/oc8051_intc_arb.sv
// Combinational winner select: highest level wins, lowest index breaks ties.
module oc8051_intc_arb #(
    parameter int NSRC = 5,
    parameter int LW   = 1
) (
    input  logic [NSRC-1:0]    i_cand,
    input  logic [NSRC*LW-1:0] i_lvl,
    output logic               o_valid,
    output logic [2:0]         o_idx,
    output logic [LW-1:0]      o_lvl
);

    // Scan upward; a later source only replaces the pick on a strictly higher level
    always_comb begin
        o_valid = 1'b0;
        o_idx   = 3'd0;
        o_lvl   = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (i_cand[i] && (!o_valid || (i_lvl[i*LW +: LW] > o_lvl))) begin
                o_valid = 1'b1;
                o_idx   = 3'(i);
                o_lvl   = i_lvl[i*LW +: LW];
            end
        end
    end

endmodule

// File: rtl/oc8051_intc.sv
// Parametrised nesting interrupt controller: flags, SFR file, nesting mask, request output.
module oc8051_intc
    import oc8051_intc_pkg::*;
#(
    parameter int         NSRC     = 5,
    parameter int         NLVL     = 2,
    parameter logic [7:0] BASE     = 8'hE8,
    parameter logic [7:0] VEC_BASE = DEF_VEC_BASE,
    parameter logic [7:0] VEC_STEP = DEF_VEC_STEP,
    localparam int        LW       = (NLVL == 4) ? 2 : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr,
    input  logic [7:0]      wr_addr,
    input  logic [7:0]      data_in,
    input  logic [7:0]      rd_addr,
    output logic [7:0]      data_out,
    input  logic [NSRC-1:0] src,
    output logic            o_int,     // "int" is a reserved word in SystemVerilog
    output logic [7:0]      int_vec,
    input  logic            ack,
    input  logic            reti,
    output logic [LW-1:0]   act_lvl
);

    // Implemented bits of an IPL register holding sources first..first+3
    function automatic logic [7:0] ipl_mask(input int first);
        logic [7:0] m;
        m = 8'h00;
        for (int j = 0; j < 4; j++) begin
            if (first + j < NSRC) begin
                for (int b = 0; b < LW; b++) m[j*LW + b] = 1'b1;
            end
        end
        return m;
    endfunction

    localparam logic [7:0] IPL0_MASK = ipl_mask(0);
    localparam logic [7:0] IPL1_MASK = ipl_mask(4);

    logic            r_gctl;
    logic [NSRC-1:0] r_ien, r_ityp, r_flg, r_src_d;
    logic [7:0]      r_ipl0, r_ipl1;
    logic [NLVL-1:0] r_act;
    logic            r_int;
    logic [7:0]      r_vec;
    logic [2:0]      r_idx;
    logic [LW-1:0]   r_lvl;
    logic [7:0]      r_dout;

    logic [7:0]         w_wr_ofs, w_rd_ofs, w_rd_data, w_vec;
    logic               w_wr_hit, w_rd_hit, w_iflg_wr, w_ack_eff, w_int_nxt;
    logic [NSRC-1:0]    w_ack_clr, w_flg_nxt, w_cand;
    logic [NSRC*LW-1:0] w_lvl_flat;
    logic [NLVL-1:0]    w_act_nxt;
    logic [1:0]         w_act_hi, w_nxt_hi;
    logic               w_win_valid;
    logic [2:0]         w_win_idx;
    logic [LW-1:0]      w_win_lvl;

    assign w_wr_ofs  = wr_addr - BASE;
    assign w_rd_ofs  = rd_addr - BASE;
    assign w_wr_hit  = wr && (w_wr_ofs < NUM_REGS);
    assign w_rd_hit  = (w_rd_ofs < NUM_REGS);
    assign w_iflg_wr = w_wr_hit && (w_wr_ofs == OFS_IFLG);

    // An ack only counts while a request is actually presented
    assign w_ack_eff = ack && r_int;
    assign w_act_hi  = hi_bit(4'(r_act));
    assign w_nxt_hi  = hi_bit(4'(w_act_nxt));

    // Unpack per-source priority fields from the two IPL bytes
    always_comb begin
        w_lvl_flat = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_lvl_flat[i*LW +: LW] = (i < 4) ? r_ipl0[(i % 4)*LW +: LW]
                                             : r_ipl1[(i % 4)*LW +: LW];
        end
    end

    // Edge flags: hardware set beats software write and ack clear; level flags track src
    always_comb begin
        w_ack_clr = '0;
        w_flg_nxt = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_ack_clr[i] = w_ack_eff && (r_idx == 3'(i)) && r_ityp[i];
            if (r_ityp[i]) begin
                if (w_iflg_wr)         w_flg_nxt[i] = data_in[i];
                else if (w_ack_clr[i]) w_flg_nxt[i] = 1'b0;
                else                   w_flg_nxt[i] = r_flg[i];
                w_flg_nxt[i] = w_flg_nxt[i] | (src[i] & ~r_src_d[i]);
            end else begin
                w_flg_nxt[i] = w_iflg_wr ? data_in[i] : src[i];
            end
        end
    end

    // Nesting mask: reti retires the top level first, then ack pushes the winner's level
    always_comb begin
        w_act_nxt = r_act;
        for (int l = 0; l < NLVL; l++) begin
            if (reti && (r_act != '0) && (w_act_hi == 2'(l))) w_act_nxt[l] = 1'b0;
        end
        for (int l = 0; l < NLVL; l++) begin
            if (w_ack_eff && (r_lvl == LW'(l))) w_act_nxt[l] = 1'b1;
        end
    end

    // Arbitrate on current flags minus the one being acked, against the post-ack mask,
    // so int drops right after ack without delaying fresh requests.
    assign w_cand = r_flg & r_ien & ~w_ack_clr;

    oc8051_intc_arb #(
        .NSRC (NSRC),
        .LW   (LW)
    ) u_arb (
        .i_cand  (w_cand),
        .i_lvl   (w_lvl_flat),
        .o_valid (w_win_valid),
        .o_idx   (w_win_idx),
        .o_lvl   (w_win_lvl)
    );

    assign w_int_nxt = r_gctl && w_win_valid &&
                       ((w_act_nxt == '0) || (w_win_lvl > LW'(w_nxt_hi)));
    assign w_vec     = VEC_BASE + VEC_STEP * {5'd0, w_win_idx};

    // SFR read mux; unmapped offsets read zero
    always_comb begin
        w_rd_data = 8'h00;
        if (w_rd_hit) begin
            case (w_rd_ofs)
                OFS_GCTL: w_rd_data = {7'd0, r_gctl};
                OFS_IEN:  w_rd_data = 8'(r_ien);
                OFS_ITYP: w_rd_data = 8'(r_ityp);
                OFS_IFLG: w_rd_data = 8'(r_flg);
                OFS_IPL0: w_rd_data = r_ipl0;
                OFS_IPL1: w_rd_data = r_ipl1;
                default:  w_rd_data = 8'h00;
            endcase
        end
    end

    // State registers: SFRs, flags, nesting mask, registered request and read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gctl  <= 1'b0;
            r_ien   <= '0;
            r_ityp  <= '0;
            r_flg   <= '0;
            r_ipl0  <= 8'h00;
            r_ipl1  <= 8'h00;
            r_src_d <= '1;
            r_act   <= '0;
            r_int   <= 1'b0;
            r_vec   <= 8'h00;
            r_idx   <= 3'd0;
            r_lvl   <= '0;
            r_dout  <= 8'h00;
        end else begin
            r_src_d <= src;
            r_flg   <= w_flg_nxt;
            r_act   <= w_act_nxt;
            r_int   <= w_int_nxt;
            r_vec   <= w_int_nxt ? w_vec : 8'h00;
            r_idx   <= w_win_idx;
            r_lvl   <= w_win_lvl;
            if (w_wr_hit) begin
                case (w_wr_ofs)
                    OFS_GCTL: r_gctl <= data_in[0];
                    OFS_IEN:  r_ien  <= data_in[NSRC-1:0];
                    OFS_ITYP: r_ityp <= data_in[NSRC-1:0];
                    OFS_IPL0: r_ipl0 <= data_in & IPL0_MASK;
                    OFS_IPL1: r_ipl1 <= data_in & IPL1_MASK;
                    default:  ;
                endcase
            end
            r_dout <= (w_wr_hit && (wr_addr == rd_addr)) ? data_in : w_rd_data;
        end
    end

    assign o_int    = r_int;
    assign int_vec  = r_vec;
    assign data_out = r_dout;
    assign act_lvl  = LW'(w_act_hi);

endmodule

// File: tb/tb_oc8051_intc.sv
// Directed bench for oc8051_intc: SFR vector table plus hand-written interrupt sequences.
module tb_oc8051_intc;

    localparam logic [7:0] BASE = 8'hE8;
    localparam logic [7:0] GCTL = 8'd0, IEN = 8'd1, ITYP = 8'd2, IFLG = 8'd3, IPL0 = 8'd4, IPL1 = 8'd5;

    logic       clk = 1'b0;
    logic       rst, wr, ack, reti, o_int;
    logic [7:0] wr_addr, data_in, rd_addr, data_out, int_vec;
    logic [4:0] src;
    logic [0:0] act_lvl;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       wr;
        logic [7:0] wa;
        logic [7:0] wd;
        logic [7:0] ra;
        logic [7:0] exp;
    } sfr_vec_t;

    sfr_vec_t tbl[15];

    always #5 clk = ~clk;

    oc8051_intc #(.NSRC(5), .NLVL(2), .BASE(BASE), .VEC_BASE(8'h03), .VEC_STEP(8'h08)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .wr_addr  (wr_addr),
        .data_in  (data_in),
        .rd_addr  (rd_addr),
        .data_out (data_out),
        .src      (src),
        .o_int    (o_int),
        .int_vec  (int_vec),
        .ack      (ack),
        .reti     (reti),
        .act_lvl  (act_lvl)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wr_reg(input logic [7:0] ofs, input logic [7:0] val);
        wr = 1'b1; wr_addr = BASE + ofs; data_in = val;
        tick();
        wr = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [7:0] ofs, input logic [7:0] exp);
        rd_addr = BASE + ofs;
        tick();
        chk(name, data_out, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [4:0] m);
        src = src | m;
        tick();
        src = src & ~m;
    endtask

    task automatic do_ack();
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic do_reti();
        reti = 1'b1; tick(); reti = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; wr_addr = 8'h00; data_in = 8'h00; rd_addr = 8'h00;
        src = 5'b0; ack = 1'b0; reti = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_int", o_int, 8'h00);
        chk("rst_vec", int_vec, 8'h00);
        chk("rst_act", act_lvl, 8'h00);
        chk("rst_dout", data_out, 8'h00);

        // SFR access: write-through, implemented-bit masking, unmapped addresses
        tbl[0]  = '{1'b1, 8'hE8, 8'hFF, 8'hE8, 8'hFF};
        tbl[1]  = '{1'b0, 8'h00, 8'h00, 8'hE8, 8'h01};
        tbl[2]  = '{1'b1, 8'hE9, 8'hFF, 8'hEA, 8'h00};
        tbl[3]  = '{1'b0, 8'h00, 8'h00, 8'hE9, 8'h1F};
        tbl[4]  = '{1'b1, 8'hEA, 8'h13, 8'hEA, 8'h13};
        tbl[5]  = '{1'b0, 8'h00, 8'h00, 8'hEA, 8'h13};
        tbl[6]  = '{1'b1, 8'hEC, 8'hFF, 8'hEC, 8'hFF};
        tbl[7]  = '{1'b0, 8'h00, 8'h00, 8'hEC, 8'h0F};
        tbl[8]  = '{1'b1, 8'hED, 8'hFF, 8'hED, 8'hFF};
        tbl[9]  = '{1'b0, 8'h00, 8'h00, 8'hED, 8'h01};
        tbl[10] = '{1'b0, 8'h00, 8'h00, 8'hEE, 8'h00};
        tbl[11] = '{1'b1, 8'hEE, 8'h55, 8'hEE, 8'h00};
        tbl[12] = '{1'b0, 8'h00, 8'h00, 8'hE7, 8'h00};
        tbl[13] = '{1'b1, 8'hE9, 8'h1F, 8'hE9, 8'h1F};
        tbl[14] = '{1'b0, 8'h00, 8'h00, 8'hEB, 8'h00};
        for (int i = 0; i < 15; i++) begin
            wr = tbl[i].wr; wr_addr = tbl[i].wa; data_in = tbl[i].wd; rd_addr = tbl[i].ra;
            tick();
            wr = 1'b0;
            chk($sformatf("sfr%0d", i), data_out, tbl[i].exp);
        end
        chk("sfr_no_int", o_int, 8'h00);
        do_reset();

        // Single edge source 1
        wr_reg(ITYP, 8'h02); wr_reg(IEN, 8'h02); wr_reg(GCTL, 8'h01);
        pulse(5'b00010);
        chk("a_int_lat1", o_int, 8'h00);
        tick();
        chk("a_int", o_int, 8'h01);
        chk("a_vec", int_vec, 8'h0B);
        do_ack();
        chk("a_int_ack", o_int, 8'h00);
        chk("a_act_ack", act_lvl, 8'h00);
        rd_chk("a_iflg", IFLG, 8'h00);
        do_reti();
        do_reset();

        // Nesting: source 0 at level 0, source 3 at level 1
        wr_reg(ITYP, 8'h09); wr_reg(IEN, 8'h09); wr_reg(IPL0, 8'h08); wr_reg(GCTL, 8'h01);
        pulse(5'b00001); tick();
        chk("b_int0", o_int, 8'h01);
        chk("b_vec0", int_vec, 8'h03);
        do_ack();
        chk("b_int0_ack", o_int, 8'h00);
        chk("b_act0", act_lvl, 8'h00);
        pulse(5'b01000); tick();
        chk("b_int3", o_int, 8'h01);
        chk("b_vec3", int_vec, 8'h1B);
        do_ack();
        chk("b_act1", act_lvl, 8'h01);
        chk("b_int3_ack", o_int, 8'h00);
        do_reti();
        chk("b_act_reti1", act_lvl, 8'h00);
        pulse(5'b00001); tick();
        chk("b_same_lvl_blocked", o_int, 8'h00);
        do_reti();
        chk("b_int_after_empty", o_int, 8'h01);
        chk("b_vec_after_empty", int_vec, 8'h03);
        do_ack(); do_reti();
        chk("b_act_end", act_lvl, 8'h00);
        do_reset();

        // Same-level tie, then higher-level arrival replacing the vector, then reset mid-service
        wr_reg(ITYP, 8'h1C); wr_reg(IEN, 8'h1C); wr_reg(IPL0, 8'h08); wr_reg(GCTL, 8'h01);
        pulse(5'b10100); tick();
        chk("c_int", o_int, 8'h01);
        chk("c_vec_first", int_vec, 8'h13);
        do_ack();
        chk("c_int_ack", o_int, 8'h00);
        do_reti();
        chk("c_int_second", o_int, 8'h01);
        chk("c_vec_second", int_vec, 8'h23);
        pulse(5'b01000);
        chk("c_vec_hold", int_vec, 8'h23);
        tick();
        chk("c_vec_preempt", int_vec, 8'h1B);
        do_ack();
        chk("c_act_hi", act_lvl, 8'h01);
        chk("c_int_low_blocked", o_int, 8'h00);
        do_reset();
        chk("c_rst_act", act_lvl, 8'h00);
        chk("c_rst_int", o_int, 8'h00);
        rd_chk("c_rst_iflg", IFLG, 8'h00);

        // Level source 2, global disable, ack while idle
        wr_reg(IEN, 8'h04); wr_reg(GCTL, 8'h01);
        src = 5'b00100;
        tick(); tick();
        chk("d_int", o_int, 8'h01);
        chk("d_vec", int_vec, 8'h13);
        do_ack();
        chk("d_int_ack", o_int, 8'h00);
        rd_chk("d_iflg_held", IFLG, 8'h04);
        do_reti();
        chk("d_int_reti", o_int, 8'h01);
        wr_reg(GCTL, 8'h00);
        chk("d_int_gctl_lag", o_int, 8'h01);
        tick();
        chk("d_int_gctl_off", o_int, 8'h00);
        do_ack();
        chk("d_ack_ignored", act_lvl, 8'h00);
        wr_reg(GCTL, 8'h01);
        tick();
        chk("d_int_reen", o_int, 8'h01);
        src = 5'b00000; rd_addr = BASE + IFLG;
        tick();
        chk("d_iflg_pre", data_out, 8'h04);
        tick();
        chk("d_iflg_low", data_out, 8'h00);
        do_reset();

        // Software clear colliding with a hardware edge; line held through reset
        wr_reg(ITYP, 8'h01);
        wr = 1'b1; wr_addr = BASE + IFLG; data_in = 8'h00; src = 5'b00001;
        tick();
        wr = 1'b0;
        rd_chk("e_set_wins", IFLG, 8'h01);
        wr_reg(IFLG, 8'h00);
        rd_chk("e_sw_clear", IFLG, 8'h00);
        do_reset();
        wr_reg(ITYP, 8'h01); wr_reg(IFLG, 8'h00);
        tick();
        rd_chk("e_no_edge_after_rst", IFLG, 8'h00);
        src = 5'b00000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
